// File: rtl/s9io_work_tx_framer_if.sv
// Work framer bus: FIFO read side (FWFT head, count, pop) plus the byte
// stream toward the work UART transmitter.
interface s9io_work_tx_framer_if #(
  parameter int FIFO_CNT_W = 11
);
  logic [31:0]           fifo_data;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_rd;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  fifo_data, fifo_empty, fifo_count, tx_ready,
    output fifo_rd, tx_data, tx_valid
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_count, tx_ready,
    input  fifo_rd, tx_data, tx_valid
  );
endinterface

// File: rtl/s9io_work_tx_framer.sv
// Work frame builder: pops one complete work from the work TX FIFO and
// streams it as 0x21, LEN, ID, payload words (LSB first), CRC16 (hi, lo).
// Consecutive frame starts are paced by work_time.
module s9io_work_tx_framer #(
  parameter int FIFO_CNT_W  = 11,
  parameter int WORK_TIME_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             midstate_cnt,
  input  logic [WORK_TIME_W-1:0] work_time,
  s9io_work_tx_framer_if.master  bus,
  output logic [7:0]             last_work_id,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_ID, S_LOAD, S_DATA, S_CRC_H, S_CRC_L
  } state_t;

  state_t                 state;
  logic [1:0]             ms_q;
  logic [7:0]             work_id_q;
  logic [23:0]            word_q;
  logic [1:0]             byte_sel;
  logic [5:0]             words_left;
  logic [15:0]            crc_q;
  logic [15:0]            crc_next;
  logic [WORK_TIME_W-1:0] timer_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic                   fifo_rd_q;
  logic                   busy_q;
  logic [7:0]             last_id_q;
  logic [FIFO_CNT_W-1:0]  need_cnt;
  logic                   start_ok;
  logic                   accept;

  // CRC-16/CCITT-FALSE update by one byte, MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Decrement that saturates at zero
  function automatic logic [WORK_TIME_W-1:0] sat_dec(input logic [WORK_TIME_W-1:0] v);
    return (v == '0) ? '0 : (v - WORK_TIME_W'(1));
  endfunction

  // Payload words following word0: 8N+3 with N = 1, 2 or 4 (code 3 acts as 4)
  function automatic logic [5:0] words_after_id(input logic [1:0] ms);
    case (ms)
      2'd0:    return 6'd11;
      2'd1:    return 6'd19;
      default: return 6'd35;
    endcase
  endfunction

  // LEN byte 17 + 32N
  function automatic logic [7:0] len_byte(input logic [1:0] ms);
    case (ms)
      2'd0:    return 8'h31;
      2'd1:    return 8'h51;
      default: return 8'h91;
    endcase
  endfunction

  assign accept           = tx_valid_q && bus.tx_ready;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.fifo_rd      = fifo_rd_q;
  assign busy             = busy_q;
  assign last_work_id     = last_id_q;

  // Start needs a whole work in the FIFO, enable and an expired pacing timer
  always_comb begin
    need_cnt = FIFO_CNT_W'(words_after_id(midstate_cnt)) + FIFO_CNT_W'(1);
    start_ok = enable && !bus.fifo_empty && (bus.fifo_count >= need_cnt) && (timer_q == '0);
    crc_next = crc16_step(crc_q, tx_data_q);
  end

  // Pacing timer: the load edge counts as the first decrement, so frame
  // starts land exactly work_time+1 cycles apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state == S_HDR && accept) begin
      timer_q <= sat_dec(work_time);
    end else begin
      timer_q <= sat_dec(timer_q);
    end
  end

  // Frame FSM with registered stream, pop strobe and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ms_q       <= 2'd0;
      work_id_q  <= 8'h00;
      word_q     <= 24'h0;
      byte_sel   <= 2'd0;
      words_left <= 6'd0;
      crc_q      <= 16'hFFFF;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      fifo_rd_q  <= 1'b0;
      busy_q     <= 1'b0;
      last_id_q  <= 8'h00;
    end else begin
      fifo_rd_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            ms_q       <= midstate_cnt;
            work_id_q  <= bus.fifo_data[7:0];
            fifo_rd_q  <= 1'b1;
            busy_q     <= 1'b1;
            crc_q      <= 16'hFFFF;
            tx_data_q  <= 8'h21;
            tx_valid_q <= 1'b1;
            state      <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            crc_q     <= crc_next;
            tx_data_q <= len_byte(ms_q);
            state     <= S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            crc_q     <= crc_next;
            tx_data_q <= work_id_q;
            state     <= S_ID;
          end
        end
        S_ID: begin
          if (accept) begin
            crc_q      <= crc_next;
            last_id_q  <= tx_data_q;
            tx_valid_q <= 1'b0;
            words_left <= words_after_id(ms_q);
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // An empty FIFO (e.g. software flush) simply parks the frame here
          if (!bus.fifo_empty) begin
            word_q     <= bus.fifo_data[31:8];
            tx_data_q  <= bus.fifo_data[7:0];
            tx_valid_q <= 1'b1;
            fifo_rd_q  <= 1'b1;
            byte_sel   <= 2'd0;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            crc_q <= crc_next;
            if (byte_sel == 2'd3) begin
              words_left <= words_left - 6'd1;
              if (words_left == 6'd1) begin
                tx_data_q <= crc_next[15:8];
                state     <= S_CRC_H;
              end else begin
                tx_valid_q <= 1'b0;
                state      <= S_LOAD;
              end
            end else begin
              tx_data_q <= word_q[7:0];
              word_q    <= {8'h00, word_q[23:8]};
              byte_sel  <= byte_sel + 2'd1;
            end
          end
        end
        S_CRC_H: begin
          if (accept) begin
            tx_data_q <= crc_q[7:0];
            state     <= S_CRC_L;
          end
        end
        S_CRC_L: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s9io_work_tx_framer.sv
// Directed bench for the work TX framer: FIFO model, byte logger, and one
// task per scenario comparing against a frame/CRC model built here.
module tb_s9io_work_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  midstate_cnt = 2'd0;
  logic [23:0] work_time = 24'd0;
  logic [7:0]  last_work_id;
  logic        busy;

  always #5 clk = ~clk;

  s9io_work_tx_framer_if #(.FIFO_CNT_W(11)) bus ();

  s9io_work_tx_framer #(.FIFO_CNT_W(11), .WORK_TIME_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .midstate_cnt (midstate_cnt),
    .work_time    (work_time),
    .bus          (bus),
    .last_work_id (last_work_id),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;

  // FIFO model (first-word-fall-through)
  logic [31:0] mem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_hold = 1'b0;
  logic fifo_flush = 1'b0;

  assign bus.fifo_data  = mem[rd_ptr[7:0]];
  assign bus.fifo_empty = fifo_hold || (wr_ptr == rd_ptr);
  assign bus.fifo_count = fifo_hold ? 11'd0 : 11'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  // Sink readiness
  logic bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.tx_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Byte logger and stall monitor
  int         cyc = 0;
  logic [7:0] log_b [0:4095];
  int         log_t [0:4095];
  int         nlog = 0;
  int         nrd = 0;
  int         stall_viol = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) stall_viol <= stall_viol + 1;
      if (bus.tx_valid && bus.tx_ready) begin
        log_b[nlog] <= bus.tx_data;
        log_t[nlog] <= cyc;
        nlog <= nlog + 1;
      end
      if (bus.tx_valid && !bus.tx_ready) stall_cnt <= stall_cnt + 1;
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
      if (bus.fifo_rd) nrd <= nrd + 1;
    end
  end

  // Expected frame
  logic [7:0] exp_b [0:255];
  int         exp_n;

  task automatic build_exp(input logic [7:0] id, input int n, input logic [7:0] base);
    int w;
    logic [15:0] c;
    logic fb;
    w = 4 + 8 * n;
    exp_b[0] = 8'h21;
    exp_b[1] = 8'(17 + 32 * n);
    exp_b[2] = id;
    for (int j = 0; j < 4 * (w - 1); j++) exp_b[3 + j] = base + 8'(j);
    exp_n = 3 + 4 * (w - 1);
    c = 16'hFFFF;
    for (int i = 0; i < exp_n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ exp_b[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    exp_b[exp_n]     = c[15:8];
    exp_b[exp_n + 1] = c[7:0];
    exp_n = exp_n + 2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Words first..last of a work; payload bytes count up from base
  task automatic push_work(input logic [7:0] id, input logic [7:0] base, input int first, input int last);
    logic [7:0] b;
    for (int k = first; k <= last; k++) begin
      if (k == 0) begin
        push_word({24'hA5A5A5, id});
      end else begin
        b = base + 8'(4 * (k - 1));
        push_word({b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && nlog < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ok = (nlog >= target);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", bus.fifo_rd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (last_work_id !== 8'h00) begin failures++; $display("FAIL reset_last_id got=%h exp=00", last_work_id); end
    step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_n1_frame();
    int s, r;
    bit ok;
    build_exp(8'h5A, 1, 8'h00);
    s = nlog; r = nrd;
    step();
    midstate_cnt = 2'd0; work_time = 24'd0; enable = 1'b1;
    push_work(8'h5A, 8'h00, 0, 11);
    wait_bytes(s + 49, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL n1_timeout got=%0d exp=%0d bytes", nlog - s, 49); end
    checks++; if (nlog - s !== 49) begin failures++; $display("FAIL n1_len got=%0d exp=49", nlog - s); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL n1_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    checks++; if (last_work_id !== 8'h5A) begin failures++; $display("FAIL n1_last_id got=%h exp=5a", last_work_id); end
    checks++; if (nrd - r !== 12) begin failures++; $display("FAIL n1_pops got=%0d exp=12", nrd - r); end
    checks++; if (log_t[s + 48] - log_t[s] !== 59) begin failures++; $display("FAIL n1_duration got=%0d exp=59", log_t[s + 48] - log_t[s]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL n1_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_partial_start();
    int s, r;
    bit ok;
    build_exp(8'h66, 1, 8'h10);
    s = nlog; r = nrd;
    step();
    push_work(8'h66, 8'h10, 0, 10);
    repeat (20) @(negedge clk);
    checks++; if (nlog !== s) begin failures++; $display("FAIL partial_no_bytes got=%0d exp=%0d", nlog, s); end
    checks++; if (nrd !== r) begin failures++; $display("FAIL partial_no_pop got=%0d exp=%0d", nrd, r); end
    step();
    push_work(8'h66, 8'h10, 11, 11);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL partial_busy_pre got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (bus.fifo_rd !== 1'b1) begin failures++; $display("FAIL start_fifo_rd got=%b exp=1", bus.fifo_rd); end
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h21) begin failures++; $display("FAIL start_hdr got=%b/%h exp=1/21", bus.tx_valid, bus.tx_data); end
    wait_bytes(s + 49, 200, ok);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL partial_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
  endtask

  task automatic test_enable_drop();
    int s;
    bit ok;
    s = nlog;
    step();
    push_work(8'h81, 8'h20, 0, 11);
    push_work(8'h82, 8'h60, 0, 11);
    wait_busy();
    step();
    enable = 1'b0;
    wait_bytes(s + 49, 200, ok);
    repeat (100) @(negedge clk);
    checks++; if (nlog - s !== 49) begin failures++; $display("FAIL endrop_bytes got=%0d exp=49", nlog - s); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL endrop_busy got=%b exp=0", busy); end
    checks++; if (bus.fifo_count !== 11'd12) begin failures++; $display("FAIL endrop_fifo got=%0d exp=12", bus.fifo_count); end
    build_exp(8'h81, 1, 8'h20);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL endrop_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    step();
    enable = 1'b1;
    wait_bytes(s + 98, 200, ok);
    build_exp(8'h82, 1, 8'h60);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + 49 + i] !== exp_b[i]) begin failures++; $display("FAIL reenable_byte[%0d] got=%h exp=%h", i, log_b[s + 49 + i], exp_b[i]); end
    end
  endtask

  task automatic test_midstates();
    int s, r;
    bit ok;
    // N=2, midstate field changed to N=1 mid-frame
    build_exp(8'h11, 2, 8'h40);
    s = nlog; r = nrd;
    step();
    midstate_cnt = 2'd1;
    push_work(8'h11, 8'h40, 0, 19);
    wait_busy();
    step();
    midstate_cnt = 2'd0;
    wait_bytes(s + 81, 300, ok);
    checks++; if (nlog - s !== 81) begin failures++; $display("FAIL n2_len got=%0d exp=81", nlog - s); end
    checks++; if (nrd - r !== 20) begin failures++; $display("FAIL n2_pops got=%0d exp=20", nrd - r); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL n2_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    // Code 3 behaves as N=4, field changed to N=2 mid-frame
    build_exp(8'hC3, 4, 8'h90);
    s = nlog; r = nrd;
    step();
    midstate_cnt = 2'd3;
    push_work(8'hC3, 8'h90, 0, 35);
    wait_busy();
    step();
    midstate_cnt = 2'd1;
    wait_bytes(s + 145, 500, ok);
    checks++; if (nlog - s !== 145) begin failures++; $display("FAIL n4_len got=%0d exp=145", nlog - s); end
    checks++; if (nrd - r !== 36) begin failures++; $display("FAIL n4_pops got=%0d exp=36", nrd - r); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL n4_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    step();
    midstate_cnt = 2'd0;
  endtask

  task automatic test_back_to_back();
    int s, r;
    bit ok;
    s = nlog; r = nrd;
    step();
    work_time = 24'd0;
    push_work(8'hA1, 8'h00, 0, 11);
    push_work(8'hA2, 8'h33, 0, 11);
    wait_bytes(s + 98, 300, ok);
    checks++; if (log_t[s + 49] - log_t[s] !== 61) begin failures++; $display("FAIL b2b_spacing got=%0d exp=61", log_t[s + 49] - log_t[s]); end
    checks++; if (nrd - r !== 24) begin failures++; $display("FAIL b2b_pops got=%0d exp=24", nrd - r); end
    build_exp(8'hA2, 1, 8'h33);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + 49 + i] !== exp_b[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, log_b[s + 49 + i], exp_b[i]); end
    end
  endtask

  task automatic test_backpressure();
    int s, st0, v0;
    bit ok;
    build_exp(8'h5A, 1, 8'h00);
    s = nlog; st0 = stall_cnt; v0 = stall_viol;
    step();
    bp_en = 1'b1;
    push_work(8'h5A, 8'h00, 0, 11);
    wait_bytes(s + 49, 800, ok);
    bp_en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d exp=49 bytes", nlog - s); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    checks++; if (stall_viol !== v0) begin failures++; $display("FAIL bp_stable got=%0d exp=%0d unstable stalls", stall_viol - v0, 0); end
    checks++; if (!(stall_cnt > st0)) begin failures++; $display("FAIL bp_stalled got=%0d exp=>0 stall cycles", stall_cnt - st0); end
  endtask

  task automatic test_fifo_stall();
    int s, r, bad;
    bit ok;
    build_exp(8'hE7, 1, 8'h55);
    s = nlog; r = nrd;
    step();
    push_work(8'hE7, 8'h55, 0, 11);
    for (int i = 0; i < 100 && nlog < s + 10; i++) @(negedge clk);
    fifo_hold = 1'b1;
    repeat (6) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tx_valid || bus.fifo_rd) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_quiet got=%0d exp=0 active cycles", bad); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
    fifo_hold = 1'b0;
    wait_bytes(s + 49, 200, ok);
    checks++; if (nrd - r !== 12) begin failures++; $display("FAIL stall_pops got=%0d exp=12", nrd - r); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    bit ok;
    s = nlog;
    step();
    push_work(8'h77, 8'h00, 0, 11);
    for (int i = 0; i < 100 && nlog < s + 8; i++) @(negedge clk);
    for (int i = 0; i < 10 && !bus.tx_valid; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (last_work_id !== 8'h00) begin failures++; $display("FAIL rst_mid_last_id got=%h exp=00", last_work_id); end
    step();
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    s = nlog;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (nlog !== s) begin failures++; $display("FAIL rst_mid_silent got=%0d exp=%0d", nlog, s); end
    build_exp(8'h3C, 1, 8'h80);
    push_work(8'h3C, 8'h80, 0, 11);
    wait_bytes(s + 49, 200, ok);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (log_b[s + i] !== exp_b[i]) begin failures++; $display("FAIL post_rst_byte[%0d] got=%h exp=%h", i, log_b[s + i], exp_b[i]); end
    end
    checks++; if (last_work_id !== 8'h3C) begin failures++; $display("FAIL post_rst_last_id got=%h exp=3c", last_work_id); end
  endtask

  task automatic test_pacing();
    int s;
    bit ok;
    s = nlog;
    step();
    work_time = 24'd1000;
    push_work(8'hB1, 8'h00, 0, 11);
    push_work(8'hB2, 8'h70, 0, 11);
    wait_busy();
    repeat (3) step();
    // Already loaded count must not be disturbed by a new value
    work_time = 24'd5;
    wait_bytes(s + 98, 1400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pace_timeout got=%0d exp=98 bytes", nlog - s); end
    checks++; if (log_t[s + 49] - log_t[s] !== 1001) begin failures++; $display("FAIL pace_spacing got=%0d exp=1001", log_t[s + 49] - log_t[s]); end
    checks++; if (log_b[s + 49] !== 8'h21) begin failures++; $display("FAIL pace_hdr got=%h exp=21", log_b[s + 49]); end
    checks++; if (last_work_id !== 8'hB2) begin failures++; $display("FAIL pace_last_id got=%h exp=b2", last_work_id); end
  endtask

  initial begin
    test_reset();
    test_n1_frame();
    test_partial_start();
    test_enable_drop();
    test_midstates();
    test_back_to_back();
    test_backpressure();
    test_fifo_stall();
    test_reset_midframe();
    test_pacing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
